mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end placed directly upstream of the word-only data memory (128 words, indexed by address[8:2], combinational read, write at the clock edge).
- Turns CPU requests for lw/lh/lhu/lb/lbu/sw/sh/sb into word accesses, using a valid/ready request handshake and a one-cycle response pulse.
- Sub-word stores use a two-cycle read-modify-write.
- Misaligned or illegal-size requests are flagged and never reach memory.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_address.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  zero-extend sub-word loads (lbu/lhu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data; the byte/half is taken from the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load result
- resp_misalign  out  1  qualifies resp_valid; request was rejected
- mem_address  out  ADDR_W  latched address with [1:0] forced to 00
- mem_MemRead  out  1  memory read strobe
- mem_MemWrite  out  1  memory write strobe
- mem_WriteData  out  DATA_W  merged word to write
- mem_ReadData  in  DATA_W  combinational read data from memory

Behaviour:
- Reset (reset_n low, asynchronous):
  - state goes to IDLE; all request and merge registers clear to 0.
  - resp_valid=0, resp_misalign=0, resp_rdata=0.
  - mem_MemRead=0 and mem_MemWrite=0 immediately, since both are decoded combinationally from state.
  - mem_address=0, mem_WriteData=0.
- Byte order is big-endian:
  - byte offset 0 maps to bits [31:24]; offset 3 maps to [7:0].
  - half offset 0 maps to [31:16]; offset 2 maps to [15:0].
- Alignment:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=00 is misaligned.
  - size 11 is always rejected.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1, strobes low.
  - On an accept edge (req_valid & req_ready), latch write, size, unsigned, addr and wdata, then:
    - rejected request -> RESP with misalign=1;
    - load -> LOAD;
    - word store -> WRITE, with merge reg = wdata;
    - sub-word store -> RMW_RD.
- LOAD:
  - mem_MemRead=1.
  - At the edge, select the lane from mem_ReadData, sign- or zero-extend it, and register it into resp_rdata.
  - Next state RESP.
- RMW_RD:
  - mem_MemRead=1.
  - At the edge, merge reg = mem_ReadData with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Next state WRITE.
- WRITE:
  - mem_MemWrite=1, mem_MemRead=0, mem_WriteData = merge reg; memory commits at this edge.
  - Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; there is no response backpressure.
  - Next state IDLE.
- Latency, with accept edge N:
  - misaligned/illegal: resp_valid in cycle N+1;
  - load or word store: N+2;
  - sub-word store: N+3.
  - Throughput: one request per (latency+1) cycles.
- resp_rdata changes only on LOAD completion and holds between responses; store and misaligned responses leave it unchanged.
- resp_misalign is 0 on every successful response.
- req_valid outside IDLE is ignored (req_ready=0). A request held from the RESP cycle is accepted on the IDLE-cycle edge.
- Rejected requests never assert mem_MemRead or mem_MemWrite.
- Reset asserted in any state aborts the operation:
  - a WRITE that has not reached its edge is not committed;
  - no resp_valid is produced.
- mem_address and mem_WriteData are stable for the whole duration of every strobe.

Test Plan:
- Reset mid-idle with random inputs -> all outputs 0; after reset_n rises, req_ready=1 and strobes stay 0 until a request arrives.
- sw 0xDEADBEEF @0x10, then lw @0x10 -> Mem[4]=0xDEADBEEF; the lw resp_valid occurs 2 cycles after accept with resp_rdata=0xDEADBEEF and resp_misalign=0.
- Mem[4]=0x11223344, then sb wdata=0x000000AA @0x11:
  - MemRead for 1 cycle, then MemWrite for 1 cycle with WriteData=0x11AA3344; resp_valid at N+3.
  - lb @0x11 -> 0xFFFFFFAA; lbu @0x11 -> 0x000000AA.
- sh wdata=0x00008001 @0x12 onto 0x11AA3344 -> memory 0x11AA8001; lh @0x12 -> 0xFFFF8001; lhu @0x12 -> 0x00008001.
- Rejected requests (lw @0x13, sh @0x11, size=11) -> each gives resp_valid and resp_misalign=1 at N+1, zero strobe cycles, memory unchanged, resp_rdata unchanged.
- sb @0x10 with reset_n driven low during the WRITE state -> MemWrite drops within the same cycle, Mem[4] keeps its old value, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-only data memory: sub-word loads are lane
// selected and extended big-endian, sub-word stores use a read-modify-write.
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_misalign,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_MemRead,
   output logic              mem_MemWrite,
   output logic [DATA_W-1:0] mem_WriteData,
   input  logic [DATA_W-1:0] mem_ReadData
);

   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

   state_t            state;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [DATA_W-1:0] merge_q;
   logic              bad;

   // Lane selection is big-endian: byte offset 0 is bits [31:24].
   function automatic logic [31:0] lane_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (sz)
         2'b00:   lane_load = {{24{b[7] & ~uns}}, b};
         2'b01:   lane_load = {{16{h[15] & ~uns}}, h};
         default: lane_load = w;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [15:0] d);
      logic [31:0] r;
      r = w;
      if (sz == 2'b00) begin
         case (off)
            2'd0:    r[31:24] = d[7:0];
            2'd1:    r[23:16] = d[7:0];
            2'd2:    r[15:8]  = d[7:0];
            default: r[7:0]   = d[7:0];
         endcase
      end else if (off[1]) begin
         r[15:0] = d;
      end else begin
         r[31:16] = d;
      end
      lane_merge = r;
   endfunction

   assign bad = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // Request handshake: a request transfers on a rising edge where req_valid
   // and req_ready are both high; req_ready is high only in IDLE. The response
   // is a single-cycle resp_valid pulse with no backpressure.
   assign req_ready     = (state == IDLE);
   assign resp_valid    = (state == RESP);
   assign mem_MemRead   = (state == LOAD) || (state == RMW_RD);
   assign mem_MemWrite  = (state == WRITE);
   assign mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_WriteData = merge_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         size_q        <= '0;
         unsigned_q    <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         merge_q       <= '0;
         resp_rdata    <= '0;
         resp_misalign <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  size_q        <= req_size;
                  unsigned_q    <= req_unsigned;
                  addr_q        <= req_addr;
                  wdata_q       <= req_wdata[15:0];
                  resp_misalign <= bad;
                  if (bad) begin
                     state <= RESP;
                  end else if (!req_write) begin
                     state <= LOAD;
                  end else if (req_size == 2'b10) begin
                     merge_q <= req_wdata;
                     state   <= WRITE;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            LOAD: begin
               resp_rdata <= lane_load(mem_ReadData, size_q, unsigned_q, addr_q[1:0]);
               state      <= RESP;
            end
            RMW_RD: begin
               merge_q <= lane_merge(mem_ReadData, size_q, addr_q[1:0], wdata_q);
               state   <= WRITE;
            end
            WRITE:   state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a behavioural word memory, a reference load/store
// model with an expected-response queue, a vector table and corner sequences.
module tb_mem_access_unit;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic [31:0] mem_address;
   logic        mem_MemRead;
   logic        mem_MemWrite;
   logic [31:0] mem_WriteData;
   logic [31:0] mem_ReadData;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_misalign(resp_misalign), .mem_address(mem_address),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
      .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // word memory: combinational read, write at the clock edge
   logic [31:0] mem [128] = '{default: 32'h0};
   assign mem_ReadData = mem[mem_address[8:2]];
   always @(posedge clock) if (mem_MemWrite) mem[mem_address[8:2]] <= mem_WriteData;

   // scoreboard state
   logic [32:0] exp_q[$];
   logic [31:0] exp_mem [128] = '{default: 32'h0};
   logic [31:0] last_rdata = 32'h0;
   logic [31:0] exp_addr = 32'h0;
   int checks = 0;
   int errors = 0;
   int rd_total = 0, wr_total = 0, addr_bad = 0, resp_total = 0;

   always @(negedge clock) begin
      if (reset_n) begin
         if (mem_MemRead) rd_total++;
         if (mem_MemWrite) wr_total++;
         if ((mem_MemRead || mem_MemWrite) && mem_address !== exp_addr) addr_bad++;
         if (resp_valid) resp_total++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic u, input logic [1:0] off);
      logic [31:0] t;
      if (sz == 2'd2) return w;
      if (sz == 2'd0) begin
         t = (w >> ((3 - int'(off)) * 8)) & 32'hFF;
         if (!u && t[7]) t = t | 32'hFFFFFF00;
      end else begin
         t = (w >> ((2 - int'(off)) * 8)) & 32'hFFFF;
         if (!u && t[15]) t = t | 32'hFFFF0000;
      end
      return t;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic [31:0] d);
      logic [31:0] m, v;
      if (sz == 2'd2) return d;
      if (sz == 2'd0) begin
         m = 32'hFF << ((3 - int'(off)) * 8);
         v = (d & 32'hFF) << ((3 - int'(off)) * 8);
      end else begin
         m = 32'hFFFF << ((2 - int'(off)) * 8);
         v = (d & 32'hFFFF) << ((2 - int'(off)) * 8);
      end
      return (w & ~m) | v;
   endfunction

   // driver: one request from IDLE through its response, checked end to end
   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
      logic        bad, got;
      logic [32:0] exp, act;
      int          idx, lat, exp_lat, exp_rd, exp_wr, rd0, wr0, ab0;
      idx = int'(a[8:2]);
      bad = is_bad(sz, a);
      if (bad) begin
         exp_lat = 1; exp_rd = 0; exp_wr = 0;
      end else if (!w) begin
         exp_lat = 2; exp_rd = 1; exp_wr = 0;
         last_rdata = ref_load(exp_mem[idx], sz, u, a[1:0]);
      end else if (sz == 2'd2) begin
         exp_lat = 2; exp_rd = 0; exp_wr = 1;
         exp_mem[idx] = wd;
      end else begin
         exp_lat = 3; exp_rd = 1; exp_wr = 1;
         exp_mem[idx] = ref_store(exp_mem[idx], sz, a[1:0], wd);
      end
      exp = {bad, last_rdata};
      exp_addr = {a[31:2], 2'b00};
      check("req_ready_idle", 64'(req_ready), 64'd1);
      rd0 = rd_total; wr0 = wr_total; ab0 = addr_bad;
      req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      exp_q.push_back(exp);
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
         lat++;
         @(negedge clock);
         if (resp_valid) got = 1'b1;
      end
      if (!got) begin
         check("resp_timeout", 64'(lat), 64'(exp_lat));
         void'(exp_q.pop_front());
      end else begin
         act = {resp_misalign, resp_rdata};
         check("resp_data", 64'(act), 64'(exp_q.pop_front()));
         check("resp_latency", 64'(lat), 64'(exp_lat));
      end
      check("read_cycles", 64'(rd_total - rd0), 64'(exp_rd));
      check("write_cycles", 64'(wr_total - wr0), 64'(exp_wr));
      check("strobe_addr", 64'(addr_bad - ab0), 64'd0);
      @(posedge clock);
      #1;
      check("mem_word", 64'(mem[idx]), 64'(exp_mem[idx]));
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [31:0] exp_m4;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int t0, t1, n, r0;
      vecs = '{
         '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF},
         '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF},
         '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'hDEADBEEF, 32'h11223344},
         '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 32'hDEADBEEF, 32'h11AA3344},
         '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAA, 32'h11AA3344},
         '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h000000AA, 32'h11AA3344},
         '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, 32'h000000AA, 32'h11AA8001},
         '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 32'h11AA8001},
         '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h00008001, 32'h11AA8001},
         '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'h00008001, 32'h11AA8001},
         '{1'b1, 2'd1, 1'b0, 32'h11, 32'h00001234, 32'h00008001, 32'h11AA8001},
         '{1'b1, 2'd3, 1'b0, 32'h10, 32'hCAFEF00D, 32'h00008001, 32'h11AA8001},
         '{1'b0, 2'd3, 1'b1, 32'h10, 32'h0,        32'h00008001, 32'h11AA8001},
         '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11AA8001, 32'h11AA8001},
         '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000011, 32'h11AA8001},
         '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h00000001, 32'h11AA8001},
         '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'hFFFFFF80, 32'h11AA8001},
         '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0,        32'h00000080, 32'h11AA8001},
         '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h000011AA, 32'h11AA8001},
         '{1'b1, 2'd0, 1'b0, 32'h13, 32'h123456FF, 32'h000011AA, 32'h11AA80FF},
         '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11AA80FF, 32'h11AA80FF}
      };

      // reset with random inputs present
      reset_n = 1'b1;
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom_range(0, 1));
      req_addr = $urandom; req_wdata = $urandom;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_misalign", 64'(resp_misalign), 64'd0);
      check("rst_rdata", 64'(resp_rdata), 64'd0);
      check("rst_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'd0);
      check("rst_address", 64'(mem_address), 64'd0);
      check("rst_wdata", 64'(mem_WriteData), 64'd0);
      req_valid = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check("post_rst_ready", 64'(req_ready), 64'd1);
         check("post_rst_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'd0);
      end

      // vector table
      for (int i = 0; i < vecs.size(); i++) begin
         do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd);
         check($sformatf("vec%0d_rdata", i), 64'(resp_rdata), 64'(vecs[i].exp_rd));
         check($sformatf("vec%0d_mem4", i), 64'(mem[4]), 64'(vecs[i].exp_m4));
      end

      // reset mid-idle with random inputs
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3)); req_addr = $urandom; req_wdata = $urandom;
      reset_n = 1'b0;
      #2;
      check("idle_rst_rdata", 64'(resp_rdata), 64'd0);
      check("idle_rst_outs", 64'({resp_valid, resp_misalign, mem_MemRead, mem_MemWrite}), 64'd0);
      check("idle_rst_addr", 64'(mem_address), 64'd0);
      last_rdata = 32'h0;
      req_valid = 1'b0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;

      // reset asserted during the WRITE state of a byte store
      exp_addr = 32'h10;
      req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h00000055; req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 4 && !mem_MemWrite; i++) begin
         @(posedge clock);
         #1;
      end
      check("abort_reached_write", 64'(mem_MemWrite), 64'd1);
      r0 = resp_total;
      reset_n = 1'b0;
      #1;
      check("abort_write_drop", 64'({mem_MemRead, mem_MemWrite}), 64'd0);
      repeat (2) @(posedge clock);
      #1;
      check("abort_mem_kept", 64'(mem[4]), 64'(exp_mem[4]));
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("abort_no_resp", 64'(resp_total - r0), 64'd0);
      check("abort_ready", 64'(req_ready), 64'd1);
      check("abort_mem_after", 64'(mem[4]), 64'(exp_mem[4]));

      // request held continuously: next accept happens on the IDLE edge
      exp_addr = 32'h10;
      last_rdata = ref_load(exp_mem[4], 2'd2, 1'b0, 2'd0);
      exp_q.push_back({1'b0, last_rdata});
      exp_q.push_back({1'b0, last_rdata});
      req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
      req_valid = 1'b1;
      t0 = -1; t1 = -1; n = 0;
      for (int i = 1; i <= 12 && t1 < 0; i++) begin
         @(negedge clock);
         if (resp_valid) begin
            check("b2b_resp", 64'({resp_misalign, resp_rdata}), 64'(exp_q.pop_front()));
            if (n == 0) t0 = i; else t1 = i;
            n++;
         end
      end
      req_valid = 1'b0;
      check("b2b_spacing", 64'(t1 - t0), 64'd3);
      while (exp_q.size() > 0) void'(exp_q.pop_front());
      @(posedge clock);
      #1;

      // random traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 63)), $urandom);
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
